// File: rtl/prog_tick_counter_pkg.sv
// Shared defaults and direction encodings for the programmable tick counter.
package prog_tick_counter_pkg;

  localparam int DIV_W_DEF          = 28;
  localparam int CNT_W_DEF          = 4;
  localparam int DEFAULT_PERIOD_DEF = 200_000_000;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/prog_tick_counter_prescaler.sv
// Prescaler: holds the period register and the cycle counter, flags the terminal
// count one cycle ahead so the top can register tick alongside num.
module prog_tick_counter_prescaler #(
  parameter int DIV_W          = 28,
  parameter int DEFAULT_PERIOD = 200_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             period_ld,
  input  logic [DIV_W-1:0] period_in,
  output logic             tick_nxt
);

  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] period_r;
  logic [DIV_W-1:0] period_new;
  logic             terminal;

  // A zero period would never match; clamp it to one cycle.
  assign period_new = (period_in == '0) ? DIV_W'(1) : period_in;
  assign terminal   = (pre == (period_r - DIV_W'(1)));
  assign tick_nxt   = en && !clr && !period_ld && terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      period_r <= DIV_W'(DEFAULT_PERIOD);
    end else begin
      if (period_ld) begin
        period_r <= period_new;
      end
      if (clr || period_ld) begin
        pre <= '0;
      end else if (en) begin
        pre <= terminal ? '0 : (pre + DIV_W'(1));
      end
    end
  end

endmodule

// File: rtl/prog_tick_counter.sv
// Programmable clock-enable tick generator with an up/down display counter,
// wrap or saturate mode, slow_clk square wave and a wrap carry pulse.
module prog_tick_counter
  import prog_tick_counter_pkg::*;
#(
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter bit SATURATE       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             period_ld,
  input  logic [DIV_W-1:0] period_in,
  output logic             tick,
  output logic             slow_clk,
  output logic [CNT_W-1:0] num,
  output logic             carry
);

  localparam logic [CNT_W-1:0] NUM_MAX = '1;

  logic             tick_nxt;
  logic [CNT_W-1:0] num_step;
  logic             wrap;

  prog_tick_counter_prescaler #(
    .DIV_W          (DIV_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .period_ld (period_ld),
    .period_in (period_in),
    .tick_nxt  (tick_nxt)
  );

  // Value num would take on a tick; wrap marks a rollover in either direction.
  always_comb begin
    num_step = num;
    wrap     = 1'b0;
    if (dir == DIR_UP) begin
      if (num != NUM_MAX) begin
        num_step = num + CNT_W'(1);
      end else if (!SATURATE) begin
        num_step = '0;
        wrap     = 1'b1;
      end
    end else begin
      if (num != '0) begin
        num_step = num - CNT_W'(1);
      end else if (!SATURATE) begin
        num_step = NUM_MAX;
        wrap     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      slow_clk <= 1'b0;
      num      <= '0;
      carry    <= 1'b0;
    end else if (clr) begin
      tick     <= 1'b0;
      slow_clk <= 1'b0;
      num      <= '0;
      carry    <= 1'b0;
    end else begin
      tick  <= tick_nxt;
      carry <= tick_nxt && wrap;
      if (tick_nxt) begin
        num      <= num_step;
        slow_clk <= ~slow_clk;
      end
    end
  end

endmodule

// File: tb/tb_prog_tick_counter.sv
// Directed bench: a wrap-mode and a saturate-mode instance share one stimulus set.
module tb_prog_tick_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       dir = 1'b1;
  logic       period_ld = 1'b0;
  logic [7:0] period_in = 8'd0;

  logic       tick_w, slow_w, carry_w;
  logic [3:0] num_w;
  logic       tick_s, slow_s, carry_s;
  logic [3:0] num_s;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  prog_tick_counter #(.DIV_W(8), .DEFAULT_PERIOD(5), .CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .period_ld(period_ld), .period_in(period_in),
    .tick(tick_w), .slow_clk(slow_w), .num(num_w), .carry(carry_w)
  );

  prog_tick_counter #(.DIV_W(8), .DEFAULT_PERIOD(5), .CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .period_ld(period_ld), .period_in(period_in),
    .tick(tick_s), .slow_clk(slow_s), .num(num_s), .carry(carry_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    period_ld = 1'b0;
    period_in = 8'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    rst_n = 1'b0;
    en = 1'b1;
    #12;
    obs = {tick_w, slow_w, num_w, carry_w, tick_s, slow_s, num_s, carry_s};
    n_vec++;
    if (obs !== 14'd0) begin
      n_miss++;
      $display("[TB] FAIL reset got %b exp %b", obs, 14'd0);
    end
  endtask

  task automatic test_basic();
    logic [6:0] obs, exp_v;
    logic [3:0] k;
    en = 1'b1;
    dir = 1'b1;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step();
      k = 4'(c / 5);
      exp_v = {(c % 5 == 0), k[0], k, 1'b0};
      obs = {tick_w, slow_w, num_w, carry_w};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL basic c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] obs, exp_v, obs_s, exp_s;
    int k;
    en = 1'b1;
    dir = 1'b1;
    do_reset();
    for (int c = 1; c <= 85; c++) begin
      step();
      k = c / 5;
      exp_v = {(c % 5 == 0), (k % 2 == 1), 4'(k % 16), (c == 80)};
      exp_s = {(c % 5 == 0), (k % 2 == 1), 4'((k > 15) ? 15 : k), 1'b0};
      obs = {tick_w, slow_w, num_w, carry_w};
      obs_s = {tick_s, slow_s, num_s, carry_s};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL wrap c=%0d got %b exp %b", c, obs, exp_v);
      end
      n_vec++;
      if (obs_s !== exp_s) begin
        n_miss++;
        $display("[TB] FAIL wrap_sat c=%0d got %b exp %b", c, obs_s, exp_s);
      end
    end
  endtask

  task automatic test_saturate();
    logic [6:0] obs, exp_v, obs_s, exp_s;
    int k, up;
    en = 1'b1;
    dir = 1'b0;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      step();
      k = c / 5;
      exp_s = {(c % 5 == 0), (k % 2 == 1), 4'd0, 1'b0};
      exp_v = {(c % 5 == 0), (k % 2 == 1), 4'((16 - k) % 16), (c == 5)};
      obs = {tick_w, slow_w, num_w, carry_w};
      obs_s = {tick_s, slow_s, num_s, carry_s};
      n_vec++;
      if (obs_s !== exp_s) begin
        n_miss++;
        $display("[TB] FAIL sat_down c=%0d got %b exp %b", c, obs_s, exp_s);
      end
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL wrap_down c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
    dir = 1'b1;
    for (int c = 26; c <= 125; c++) begin
      step();
      k = c / 5;
      up = (c - 25) / 5;
      exp_s = {(c % 5 == 0), (k % 2 == 1), 4'((up > 15) ? 15 : up), 1'b0};
      obs_s = {tick_s, slow_s, num_s, carry_s};
      n_vec++;
      if (obs_s !== exp_s) begin
        n_miss++;
        $display("[TB] FAIL sat_up c=%0d got %b exp %b", c, obs_s, exp_s);
      end
    end
  endtask

  task automatic test_period_load();
    logic [6:0] obs, exp_v;
    logic [3:0] k;
    en = 1'b1;
    dir = 1'b1;
    do_reset();
    repeat (3) step();
    period_ld = 1'b1;
    period_in = 8'd2;
    for (int c = 4; c <= 12; c++) begin
      step();
      period_ld = 1'b0;
      k = 4'((c - 4) / 2);
      exp_v = {(c >= 6 && c % 2 == 0), k[0], k, 1'b0};
      obs = {tick_w, slow_w, num_w, carry_w};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL period2 c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
    period_ld = 1'b1;
    period_in = 8'd0;
    for (int c = 13; c <= 18; c++) begin
      step();
      period_ld = 1'b0;
      k = (c == 13) ? 4'd4 : 4'(c - 9);
      exp_v = {(c != 13), k[0], k, 1'b0};
      obs = {tick_w, slow_w, num_w, carry_w};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL period0 c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_enable_clr();
    logic [6:0] obs, exp_v;
    en = 1'b1;
    dir = 1'b1;
    do_reset();
    repeat (3) step();
    en = 1'b0;
    for (int c = 4; c <= 22; c++) begin
      if (c == 11) en = 1'b1;
      clr = (c == 17);
      step();
      if (c < 12)       exp_v = 7'b0_0_0000_0;
      else if (c == 12) exp_v = 7'b1_1_0001_0;
      else if (c < 17)  exp_v = 7'b0_1_0001_0;
      else if (c < 22)  exp_v = 7'b0_0_0000_0;
      else              exp_v = 7'b1_1_0001_0;
      obs = {tick_w, slow_w, num_w, carry_w};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL en_clr c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [6:0] obs, exp_v;
    logic [13:0] both;
    en = 1'b1;
    dir = 1'b1;
    do_reset();
    repeat (7) step();
    obs = {tick_w, slow_w, num_w, carry_w};
    n_vec++;
    if (obs !== 7'b0_1_0001_0) begin
      n_miss++;
      $display("[TB] FAIL pre_async got %b exp %b", obs, 7'b0_1_0001_0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    both = {tick_w, slow_w, num_w, carry_w, tick_s, slow_s, num_s, carry_s};
    n_vec++;
    if (both !== 14'd0) begin
      n_miss++;
      $display("[TB] FAIL async_reset got %b exp %b", both, 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      exp_v = (c == 5) ? 7'b1_1_0001_0 : 7'b0_0_0000_0;
      obs = {tick_w, slow_w, num_w, carry_w};
      n_vec++;
      if (obs !== exp_v) begin
        n_miss++;
        $display("[TB] FAIL post_async c=%0d got %b exp %b", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_period_load();
    test_enable_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
